video_timing_gen: RTL and testbench

//  Parametrised successor to the frame tracker. Counts lines and frames for PAL or NTSC
//  240p/288p progressive composite video and drives the N-bit resistor-ladder DAC with

---
 rtl/osd_video_pkg.sv | 43 ++++
 rtl/video_timing_gen_if.sv | 32 +++
 rtl/video_timing_counter.sv | 67 ++++++
 rtl/video_timing_gen.sv | 104 ++++++++++
 tb/tb_video_timing_gen.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/osd_video_pkg.sv
// rtl/osd_video_pkg.sv - shared constants, standard enum and level clamp for the video timing generator
// Purpose: DAC level codes, default PAL/NTSC timing, counter widths, video_std_t, clamp helper.
// Ports: none (package).
package osd_video_pkg;

    localparam int H_W  = 10;    // horizontal counter, covers up to 1024 clocks/line
    localparam int V_W  = 9;     // vertical counter, covers up to 512 lines/frame
    localparam int PX_W = 10;
    localparam int PY_W = 8;

    localparam int SYNC_LVL  = 0;
    localparam int BLANK_LVL = 9;
    localparam int BLACK_LVL = 9;
    localparam int WHITE_LVL = 31;

    localparam int DEF_LINE_CLK_PAL  = 1024;
    localparam int DEF_LINE_CLK_NTSC = 1017;
    localparam int DEF_LINES_PAL     = 312;
    localparam int DEF_LINES_NTSC    = 262;
    localparam int DEF_HSYNC_CLKS    = 75;
    localparam int DEF_ACT_X0        = 168;
    localparam int DEF_ACT_W         = 832;
    localparam int DEF_VSYNC_LINES   = 3;
    localparam int DEF_ACT_Y0        = 20;
    localparam int DEF_ACT_H         = 240;

    typedef enum logic {
        STD_PAL  = 1'b0,
        STD_NTSC = 1'b1
    } video_std_t;

    // Callers pass a zero-extended DAC code, so the compare behaves as unsigned.
    function automatic int clamp_lvl(input int lvl, input int lo, input int hi);
        if (lvl < lo) begin
            return lo;
        end
        if (lvl > hi) begin
            return hi;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - pixel request / DAC output bundle of the video timing generator
// Purpose: groups control, pixel request and DAC output signals.
// Ports: en, mode_ntsc, pix_in (to generator); pix_x, pix_y, active, dac_out,
//        new_line, new_frame, cur_ntsc (from generator).
// Modports: master = timing generator, slave = pixel source / DAC consumer.
interface video_timing_gen_if #(
    parameter int DAC_W = 5
) ();
    import osd_video_pkg::*;

    logic              en;
    logic              mode_ntsc;
    logic [DAC_W-1:0]  pix_in;
    logic [PX_W-1:0]   pix_x;
    logic [PY_W-1:0]   pix_y;
    logic              active;
    logic [DAC_W-1:0]  dac_out;
    logic              new_line;
    logic              new_frame;
    logic              cur_ntsc;

    modport master (
        input  en, mode_ntsc, pix_in,
        output pix_x, pix_y, active, dac_out, new_line, new_frame, cur_ntsc
    );

    modport slave (
        output en, mode_ntsc, pix_in,
        input  pix_x, pix_y, active, dac_out, new_line, new_frame, cur_ntsc
    );

endinterface

// File: rtl/video_timing_counter.sv
// rtl/video_timing_counter.sv - h/v position counters with frame-boundary standard latching
// Purpose: counts clocks per line and lines per frame for the standard in effect.
// Ports: clk, rst_n (async, active low), en_i (count enable), mode_ntsc_i (requested
//        standard), h_o / v_o (current position), std_o (standard in effect).
module video_timing_counter
    import osd_video_pkg::*;
#(
    parameter int LINE_CLK_PAL  = DEF_LINE_CLK_PAL,
    parameter int LINE_CLK_NTSC = DEF_LINE_CLK_NTSC,
    parameter int LINES_PAL     = DEF_LINES_PAL,
    parameter int LINES_NTSC    = DEF_LINES_NTSC
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           mode_ntsc_i,
    output logic [H_W-1:0] h_o,
    output logic [V_W-1:0] v_o,
    output video_std_t     std_o
);

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    video_std_t     std_q, std_d;
    logic [H_W-1:0] h_last;
    logic [V_W-1:0] v_last;

    assign h_last = (std_q == STD_NTSC) ? H_W'(LINE_CLK_NTSC - 1) : H_W'(LINE_CLK_PAL - 1);
    assign v_last = (std_q == STD_NTSC) ? V_W'(LINES_NTSC - 1)    : V_W'(LINES_PAL - 1);

    // The standard only changes on the frame-wrap cycle so a running frame keeps its length.
    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        std_d = std_q;
        if (en_i) begin
            if (h_q == h_last) begin
                h_d = '0;
                if (v_q == v_last) begin
                    v_d   = '0;
                    std_d = mode_ntsc_i ? STD_NTSC : STD_PAL;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q   <= '0;
            v_q   <= '0;
            std_q <= STD_PAL;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            std_q <= std_d;
        end
    end

    assign h_o   = h_q;
    assign v_o   = v_q;
    assign std_o = std_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - PAL/NTSC progressive composite timing generator driving a ladder DAC
// Purpose: decodes the active window one cycle ahead for the pixel source and registers
//          sync / blank / clamped pixel codes for the DAC.
// Ports: clk, rst_n (async, active low), vif (video_timing_gen_if.master: en, mode_ntsc,
//        pix_in in; pix_x, pix_y, active, dac_out, new_line, new_frame, cur_ntsc out).
module video_timing_gen
    import osd_video_pkg::*;
#(
    parameter int DAC_W         = 5,
    parameter int LINE_CLK_PAL  = DEF_LINE_CLK_PAL,
    parameter int LINE_CLK_NTSC = DEF_LINE_CLK_NTSC,
    parameter int LINES_PAL     = DEF_LINES_PAL,
    parameter int LINES_NTSC    = DEF_LINES_NTSC,
    parameter int HSYNC_CLKS    = DEF_HSYNC_CLKS,
    parameter int ACT_X0        = DEF_ACT_X0,
    parameter int ACT_W         = DEF_ACT_W,
    parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
    parameter int ACT_Y0        = DEF_ACT_Y0,
    parameter int ACT_H         = DEF_ACT_H
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vif
);

    localparam logic [H_W-1:0]   ACT_X0_H   = H_W'(ACT_X0);
    localparam logic [H_W-1:0]   ACT_X1_H   = H_W'(ACT_X0 + ACT_W);
    localparam logic [H_W-1:0]   HSYNC_H    = H_W'(HSYNC_CLKS);
    localparam logic [H_W-1:0]   VS_PAL_H   = H_W'(LINE_CLK_PAL - HSYNC_CLKS);
    localparam logic [H_W-1:0]   VS_NTSC_H  = H_W'(LINE_CLK_NTSC - HSYNC_CLKS);
    localparam logic [V_W-1:0]   ACT_Y0_V   = V_W'(ACT_Y0);
    localparam logic [V_W-1:0]   ACT_Y1_V   = V_W'(ACT_Y0 + ACT_H);
    localparam logic [V_W-1:0]   VSYNC_V    = V_W'(VSYNC_LINES);
    localparam logic [DAC_W-1:0] SYNC_D     = DAC_W'(SYNC_LVL);
    localparam logic [DAC_W-1:0] BLANK_D    = DAC_W'(BLANK_LVL);

    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    video_std_t       cur_std;
    logic             active;
    logic [H_W-1:0]   vs_end;
    logic [DAC_W-1:0] dac_d, dac_q;
    logic             new_line_d, new_line_q;
    logic             new_frame_d, new_frame_q;

    video_timing_counter #(
        .LINE_CLK_PAL  (LINE_CLK_PAL),
        .LINE_CLK_NTSC (LINE_CLK_NTSC),
        .LINES_PAL     (LINES_PAL),
        .LINES_NTSC    (LINES_NTSC)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (vif.en),
        .mode_ntsc_i (vif.mode_ntsc),
        .h_o         (h),
        .v_o         (v),
        .std_o       (cur_std)
    );

    // Request stage: coordinates describe the counter position the next DAC code is built from.
    assign active = (h >= ACT_X0_H) && (h < ACT_X1_H) && (v >= ACT_Y0_V) && (v < ACT_Y1_V);
    assign vif.active = active;
    assign vif.pix_x  = active ? PX_W'(h - ACT_X0_H) : '0;
    assign vif.pix_y  = active ? PY_W'(v - ACT_Y0_V) : '0;

    // Broad-pulse lines are sync for all but the last HSYNC_CLKS clocks of the line.
    assign vs_end = (cur_std == STD_NTSC) ? VS_NTSC_H : VS_PAL_H;

    always_comb begin
        dac_d = BLANK_D;
        if (v < VSYNC_V) begin
            dac_d = (h < vs_end) ? SYNC_D : BLANK_D;
        end else if (h < HSYNC_H) begin
            dac_d = SYNC_D;
        end else if (active) begin
            dac_d = DAC_W'(clamp_lvl(int'(vif.pix_in), BLACK_LVL, WHITE_LVL));
        end
    end

    assign new_line_d  = (h == '0);
    assign new_frame_d = (h == '0) && (v == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_q       <= BLANK_D;
            new_line_q  <= 1'b0;
            new_frame_q <= 1'b0;
        end else if (vif.en) begin
            dac_q       <= dac_d;
            new_line_q  <= new_line_d;
            new_frame_q <= new_frame_d;
        end else begin
            new_line_q  <= 1'b0;
            new_frame_q <= 1'b0;
        end
    end

    assign vif.dac_out   = dac_q;
    assign vif.new_line  = new_line_q;
    assign vif.new_frame = new_frame_q;
    assign vif.cur_ntsc  = (cur_std == STD_NTSC);

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;

    localparam int DAC_W   = 5;
    localparam int LC_PAL  = 64;
    localparam int LC_NTSC = 60;
    localparam int LN_PAL  = 30;
    localparam int LN_NTSC = 26;
    localparam int HS      = 5;
    localparam int AX0     = 10;
    localparam int AW      = 40;
    localparam int VS      = 3;
    localparam int AY0     = 5;
    localparam int AH      = 20;

    typedef struct {
        int dac;
        int nl;
        int nf;
        int ntsc;
        int act;
        int px;
        int py;
    } exp_t;

    exp_t sbq[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;

    int mh = 0, mv = 0, mntsc = 0, last_dac = 9;
    int cyc = 0, last_nl = -1, last_nf = -1, nl_period = 0, nf_period = 0;

    video_timing_gen_if #(.DAC_W(DAC_W)) vif();

    video_timing_gen #(
        .DAC_W(DAC_W), .LINE_CLK_PAL(LC_PAL), .LINE_CLK_NTSC(LC_NTSC),
        .LINES_PAL(LN_PAL), .LINES_NTSC(LN_NTSC), .HSYNC_CLKS(HS),
        .ACT_X0(AX0), .ACT_W(AW), .VSYNC_LINES(VS), .ACT_Y0(AY0), .ACT_H(AH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int in_act(input int h, input int v);
        return (h >= AX0 && h < AX0 + AW && v >= AY0 && v < AY0 + AH) ? 1 : 0;
    endfunction

    function automatic int exp_dac(input int h, input int v, input int ntsc, input int pix);
        int lc;
        lc = (ntsc != 0) ? LC_NTSC : LC_PAL;
        if (v < VS) return (h < lc - HS) ? 0 : 9;
        if (h < HS) return 0;
        if (in_act(h, v) != 0) return (pix < 9) ? 9 : ((pix > 31) ? 31 : pix);
        return 9;
    endfunction

    // Reference raster: one expected output pushed per enabled-or-held clock edge.
    always @(posedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (vif.en) begin
                e.dac    = exp_dac(mh, mv, mntsc, int'(vif.pix_in));
                e.nl     = (mh == 0) ? 1 : 0;
                e.nf     = (mh == 0 && mv == 0) ? 1 : 0;
                last_dac = e.dac;
                if (mh == ((mntsc != 0) ? LC_NTSC : LC_PAL) - 1) begin
                    mh = 0;
                    if (mv == ((mntsc != 0) ? LN_NTSC : LN_PAL) - 1) begin
                        mv    = 0;
                        mntsc = vif.mode_ntsc ? 1 : 0;
                    end else begin
                        mv++;
                    end
                end else begin
                    mh++;
                end
            end else begin
                e.dac = last_dac;
                e.nl  = 0;
                e.nf  = 0;
            end
            e.ntsc = mntsc;
            e.act  = in_act(mh, mv);
            e.px   = (e.act != 0) ? mh - AX0 : 0;
            e.py   = (e.act != 0) ? mv - AY0 : 0;
            sbq.push_back(e);
        end
    end

    always @(negedge rst_n) begin
        mh = 0;
        mv = 0;
        mntsc = 0;
        last_dac = 9;
        sbq.delete();
    end

    // Monitor: compares every presented output against the scoreboard and times the strobes.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("dac_out",   int'(vif.dac_out),   e.dac);
            check("new_line",  int'(vif.new_line),  e.nl);
            check("new_frame", int'(vif.new_frame), e.nf);
            check("cur_ntsc",  int'(vif.cur_ntsc),  e.ntsc);
            check("active",    int'(vif.active),    e.act);
            check("pix_x",     int'(vif.pix_x),     e.px);
            check("pix_y",     int'(vif.pix_y),     e.py);
        end else if (!rst_n) begin
            check("rst dac_out",   int'(vif.dac_out),   9);
            check("rst new_line",  int'(vif.new_line),  0);
            check("rst new_frame", int'(vif.new_frame), 0);
            check("rst cur_ntsc",  int'(vif.cur_ntsc),  0);
        end
        if (vif.new_line) begin
            nl_period = cyc - last_nl;
            last_nl   = cyc;
        end
        if (vif.new_frame) begin
            nf_period = cyc - last_nf;
            last_nf   = cyc;
        end
    end

    task automatic wait_model(input int h, input int v, input string nm);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({"reach ", nm}, (mh == h && mv == v) ? 1 : 0, 1);
    endtask

    initial begin
        vif.en        = 1'b0;
        vif.mode_ntsc = 1'b0;
        vif.pix_in    = 5'd31;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        vif.en = 1'b1;

        repeat (2 * LC_PAL * LN_PAL + 20) @(negedge clk);
        check("line period pal",  nl_period, 64);
        check("frame period pal", nf_period, 1920);
        check("cur_ntsc pal",     int'(vif.cur_ntsc), 0);

        wait_model(0, 3, "v3");
        repeat (5) @(negedge clk);
        check("v3 h4 sync", int'(vif.dac_out), 0);
        @(negedge clk);
        check("v3 h5 blank", int'(vif.dac_out), 9);

        wait_model(10, 5, "act start");
        check("act start active", int'(vif.active), 1);
        check("act start pix_x",  int'(vif.pix_x), 0);
        check("act start pix_y",  int'(vif.pix_y), 0);
        @(negedge clk);
        check("act start dac", int'(vif.dac_out), 31);
        wait_model(49, 24, "act end");
        check("act end pix_x", int'(vif.pix_x), 39);
        check("act end pix_y", int'(vif.pix_y), 19);
        @(negedge clk);
        check("act end dac",     int'(vif.dac_out), 31);
        check("act end +1 inactive", int'(vif.active), 0);
        @(negedge clk);
        check("act end +1 blank", int'(vif.dac_out), 9);

        vif.pix_in = 5'd3;
        wait_model(20, 10, "clamp");
        @(negedge clk);
        check("clamp low", int'(vif.dac_out), 9);
        vif.pix_in = 5'd20;
        @(negedge clk);
        check("pix mid", int'(vif.dac_out), 20);
        vif.pix_in = 5'd31;

        wait_model(58, 1, "vsync");
        @(negedge clk);
        check("vsync h58 sync", int'(vif.dac_out), 0);
        @(negedge clk);
        check("vsync h59 blank", int'(vif.dac_out), 9);

        wait_model(0, 10, "mode req");
        vif.mode_ntsc = 1'b1;
        @(negedge clk);
        check("cur_ntsc holds mid frame", int'(vif.cur_ntsc), 0);
        wait_model(1, 0, "switch wrap");
        @(negedge clk);
        check("frame period at switch", nf_period, 1920);
        check("cur_ntsc after wrap", int'(vif.cur_ntsc), 1);
        wait_model(1, 0, "ntsc wrap");
        @(negedge clk);
        check("frame period ntsc", nf_period, 1560);
        check("line period ntsc",  nl_period, 60);

        wait_model(20, 12, "stall");
        vif.en = 1'b0;
        repeat (10) @(negedge clk);
        check("stall hold dac", int'(vif.dac_out), 31);
        check("stall no strobe", int'(vif.new_line), 0);
        vif.en = 1'b1;
        wait_model(1, 13, "after stall");
        @(negedge clk);
        check("stalled line period", nl_period, 70);

        wait_model(30, 15, "mid line");
        #2 rst_n = 1'b0;
        #1;
        check("async rst dac",       int'(vif.dac_out), 9);
        check("async rst new_line",  int'(vif.new_line), 0);
        check("async rst new_frame", int'(vif.new_frame), 0);
        check("async rst cur_ntsc",  int'(vif.cur_ntsc), 0);
        vif.mode_ntsc = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("restart new_frame", int'(vif.new_frame), 1);
        check("restart new_line",  int'(vif.new_line), 1);
        check("restart dac",       int'(vif.dac_out), 0);
        repeat (100) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
